// File: rtl/uart_arbiter.sv
// Two-port arbiter in front of the uart RX/TX FIFOs: round-robin grant,
// empty-gated reads and a drain-time credit counter pacing writes.
module uart_arbiter #(
   parameter int unsigned TX_DEPTH    = 16,
   parameter int unsigned BYTE_CYCLES = 1000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       p0_rd_req,
   input  logic       p1_rd_req,
   input  logic       p0_wr_req,
   input  logic       p1_wr_req,
   input  logic [7:0] p0_wdata,
   input  logic [7:0] p1_wdata,
   output logic [7:0] p0_rdata,
   output logic [7:0] p1_rdata,
   output logic       p0_ack,
   output logic       p1_ack,
   output logic       uart_wrreq,
   output logic [7:0] uart_wdata,
   output logic       uart_rdreq,
   input  logic [7:0] uart_rdata,
   input  logic       uart_empty,
   output logic [7:0] tx_level
);

   localparam int unsigned TW = (BYTE_CYCLES > 2) ? $clog2(BYTE_CYCLES) : 1;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      WR       = 2'd1,
      RD_ISSUE = 2'd2,
      RD_CAP   = 2'd3
   } state_t;

   state_t        state, state_nxt;
   logic          gnt, gnt_nxt;
   logic          last, last_nxt;
   logic          win;
   logic          credit_ok;
   logic          el0, el1;
   logic          dec;
   logic [TW-1:0] timer;

   assign credit_ok = (tx_level < 8'(TX_DEPTH));
   // A write request masks a simultaneous read from the same port.
   assign el0 = (p0_wr_req & credit_ok) | (p0_rd_req & ~p0_wr_req & ~uart_empty);
   assign el1 = (p1_wr_req & credit_ok) | (p1_rd_req & ~p1_wr_req & ~uart_empty);

   always_comb begin
      state_nxt = state;
      gnt_nxt   = gnt;
      last_nxt  = last;
      win       = 1'b0;
      case (state)
         IDLE: begin
            if (el0 | el1) begin
               win       = (el0 & el1) ? ~last : el1;
               gnt_nxt   = win;
               last_nxt  = win;
               state_nxt = (win ? p1_wr_req : p0_wr_req) ? WR : RD_ISSUE;
            end
         end
         WR:       state_nxt = IDLE;
         RD_ISSUE: state_nxt = RD_CAP;
         RD_CAP:   state_nxt = IDLE;
         default:  state_nxt = IDLE;
      endcase
   end

   // Strobes and acks are registered images of the next state.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= IDLE;
         gnt        <= 1'b0;
         last       <= 1'b1;
         uart_wrreq <= 1'b0;
         uart_rdreq <= 1'b0;
         uart_wdata <= 8'h00;
         p0_ack     <= 1'b0;
         p1_ack     <= 1'b0;
         p0_rdata   <= 8'h00;
         p1_rdata   <= 8'h00;
      end else begin
         state      <= state_nxt;
         gnt        <= gnt_nxt;
         last       <= last_nxt;
         uart_wrreq <= (state_nxt == WR);
         uart_rdreq <= (state_nxt == RD_ISSUE);
         p0_ack     <= ((state_nxt == WR) || (state_nxt == RD_CAP)) && !gnt_nxt;
         p1_ack     <= ((state_nxt == WR) || (state_nxt == RD_CAP)) && gnt_nxt;
         if (state_nxt == WR)
            uart_wdata <= gnt_nxt ? p1_wdata : p0_wdata;
         if (state == RD_CAP) begin
            if (gnt) p1_rdata <= uart_rdata;
            else     p0_rdata <= uart_rdata;
         end
      end
   end

   assign dec = (tx_level != 8'd0) && (timer == TW'(BYTE_CYCLES - 1));

   // TX credit: one outstanding byte retires every BYTE_CYCLES while non-empty.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         timer    <= '0;
         tx_level <= 8'd0;
      end else begin
         if (tx_level == 8'd0 || dec) timer <= '0;
         else                         timer <= timer + TW'(1);
         case ({uart_wrreq, dec})
            2'b10:   tx_level <= tx_level + 8'd1;
            2'b01:   tx_level <= tx_level - 8'd1;
            default: tx_level <= tx_level;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_arbiter.sv
// Directed self-checking bench for uart_arbiter (default instance plus a
// small-credit instance with TX_DEPTH=4, BYTE_CYCLES=8).
module tb_uart_arbiter;

   logic       clk;
   logic       rst_n;
   logic       p0_rd_req, p1_rd_req, p0_wr_req, p1_wr_req;
   logic [7:0] p0_wdata, p1_wdata, p0_rdata, p1_rdata;
   logic       p0_ack, p1_ack, uart_wrreq, uart_rdreq, uart_empty;
   logic [7:0] uart_wdata, uart_rdata, tx_level;
   logic [7:0] rd_byte;

   logic       c_p0_rd_req, c_p1_rd_req, c_p0_wr_req, c_p1_wr_req;
   logic [7:0] c_p0_wdata, c_p1_wdata, c_p0_rdata, c_p1_rdata;
   logic       c_p0_ack, c_p1_ack, c_uart_wrreq, c_uart_rdreq, c_uart_empty;
   logic [7:0] c_uart_wdata, c_uart_rdata, c_tx_level;

   int n_tests = 0;
   int n_fail  = 0;

   uart_arbiter u_dut (
      .clk(clk), .rst_n(rst_n),
      .p0_rd_req(p0_rd_req), .p1_rd_req(p1_rd_req),
      .p0_wr_req(p0_wr_req), .p1_wr_req(p1_wr_req),
      .p0_wdata(p0_wdata), .p1_wdata(p1_wdata),
      .p0_rdata(p0_rdata), .p1_rdata(p1_rdata),
      .p0_ack(p0_ack), .p1_ack(p1_ack),
      .uart_wrreq(uart_wrreq), .uart_wdata(uart_wdata),
      .uart_rdreq(uart_rdreq), .uart_rdata(uart_rdata),
      .uart_empty(uart_empty), .tx_level(tx_level)
   );

   uart_arbiter #(.TX_DEPTH(4), .BYTE_CYCLES(8)) u_crd (
      .clk(clk), .rst_n(rst_n),
      .p0_rd_req(c_p0_rd_req), .p1_rd_req(c_p1_rd_req),
      .p0_wr_req(c_p0_wr_req), .p1_wr_req(c_p1_wr_req),
      .p0_wdata(c_p0_wdata), .p1_wdata(c_p1_wdata),
      .p0_rdata(c_p0_rdata), .p1_rdata(c_p1_rdata),
      .p0_ack(c_p0_ack), .p1_ack(c_p1_ack),
      .uart_wrreq(c_uart_wrreq), .uart_wdata(c_uart_wdata),
      .uart_rdreq(c_uart_rdreq), .uart_rdata(c_uart_rdata),
      .uart_empty(c_uart_empty), .tx_level(c_tx_level)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // UART read model: read_data presents rd_byte the cycle after rdreq.
   always @(posedge clk) if (uart_rdreq) uart_rdata <= rd_byte;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int seen;
      int ack_cyc[6];
      int exp_d[6];
      int n_ack, cyc, maxl, lvl7;

      rst_n = 1'b0;
      {p0_rd_req, p1_rd_req, p0_wr_req, p1_wr_req} = 4'b0;
      p0_wdata = 8'h00; p1_wdata = 8'h00;
      uart_empty = 1'b1; uart_rdata = 8'h00; rd_byte = 8'h00;
      {c_p0_rd_req, c_p1_rd_req, c_p0_wr_req, c_p1_wr_req} = 4'b0;
      c_p0_wdata = 8'h00; c_p1_wdata = 8'h00;
      c_uart_empty = 1'b1; c_uart_rdata = 8'h00;
      repeat (3) tick();

      // Reset values
      check("rst_acks", {30'd0, p0_ack, p1_ack}, 32'd0);
      check("rst_strobes", {30'd0, uart_wrreq, uart_rdreq}, 32'd0);
      check("rst_wdata", uart_wdata, 32'h0);
      check("rst_rdata", {p0_rdata, p1_rdata}, 32'h0);
      check("rst_level", tx_level, 32'd0);
      rst_n = 1'b1;
      tick();

      // Single write from port 1
      p1_wr_req = 1'b1; p1_wdata = 8'h41;
      tick();
      check("wr_strobe", {29'd0, uart_wrreq, uart_rdreq, p1_ack}, 32'b101);
      check("wr_data", uart_wdata, 32'h41);
      check("wr_p0_ack", p0_ack, 32'd0);
      p1_wr_req = 1'b0;
      tick();
      check("wr_one_cycle", {30'd0, uart_wrreq, p1_ack}, 32'd0);
      check("wr_level1", tx_level, 32'd1);
      repeat (999) tick();
      check("drain_before", tx_level, 32'd1);
      tick();
      check("drain_after", tx_level, 32'd0);

      // Read gated by empty
      rd_byte = 8'hA5;
      p0_rd_req = 1'b1;
      seen = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (uart_rdreq || p0_ack || p1_ack) seen++;
      end
      check("rd_gated", seen, 32'd0);
      uart_empty = 1'b0;
      tick();
      check("rd_issue", {30'd0, uart_rdreq, p0_ack}, 32'b10);
      tick();
      check("rd_ack", {30'd0, uart_rdreq, p0_ack}, 32'b01);
      p0_rd_req = 1'b0; uart_empty = 1'b1;
      tick();
      check("rd_data", p0_rdata, 32'hA5);
      check("rd_ack_off", p0_ack, 32'd0);
      repeat (3) tick();
      check("rd_hold", p0_rdata, 32'hA5);

      // Tie-break on writes after a fresh reset
      rst_n = 1'b0; tick(); rst_n = 1'b1;
      p0_wr_req = 1'b1; p1_wr_req = 1'b1; p0_wdata = 8'h10; p1_wdata = 8'h20;
      for (int i = 0; i < 4; i++) begin
         tick();
         check("rr_ack", {30'd0, p0_ack, p1_ack}, (i % 2 == 0) ? 32'b10 : 32'b01);
         check("rr_wdata", uart_wdata, (i % 2 == 0) ? 32'h10 : 32'h20);
         tick();
         check("rr_gap", {30'd0, p0_ack, p1_ack}, 32'd0);
      end
      p0_wr_req = 1'b0; p1_wr_req = 1'b0;
      check("rr_level", tx_level, 32'd4);

      // Reset during RD_ISSUE
      rd_byte = 8'hEE;
      uart_empty = 1'b0; p1_rd_req = 1'b1;
      tick();
      check("rr_rdreq", uart_rdreq, 32'd1);
      rst_n = 1'b0;
      tick();
      check("mid_acks", {30'd0, p0_ack, p1_ack}, 32'd0);
      check("mid_strobes", {30'd0, uart_wrreq, uart_rdreq}, 32'd0);
      check("mid_level", tx_level, 32'd0);
      check("mid_rdata", {p0_rdata, p1_rdata}, 32'h0);
      rst_n = 1'b1; rd_byte = 8'h3C;
      tick();
      check("post_rdreq", uart_rdreq, 32'd1);
      tick();
      check("post_ack", {30'd0, p0_ack, p1_ack}, 32'b01);
      p1_rd_req = 1'b0; uart_empty = 1'b1;
      tick();
      check("post_rdata", {p0_rdata, p1_rdata}, 32'h003C);

      // Read and write together from port 0: write wins
      p0_rd_req = 1'b1; p0_wr_req = 1'b1; p0_wdata = 8'h5A; uart_empty = 1'b0;
      tick();
      check("rw_strobes", {29'd0, uart_wrreq, uart_rdreq, p0_ack}, 32'b101);
      check("rw_wdata", uart_wdata, 32'h5A);
      p0_rd_req = 1'b0; p0_wr_req = 1'b0; uart_empty = 1'b1;
      tick();
      check("rw_after", {30'd0, uart_wrreq, uart_rdreq}, 32'd0);

      // Credit limit on the TX_DEPTH=4 / BYTE_CYCLES=8 instance
      exp_d = '{0, 2, 4, 6, 10, 18};
      for (int i = 0; i < 6; i++) ack_cyc[i] = -1;
      n_ack = 0; cyc = 0; maxl = 0; lvl7 = -1;
      c_p0_wr_req = 1'b1; c_p0_wdata = 8'h77;
      for (int k = 0; k < 60; k++) begin
         tick();
         cyc++;
         if (c_p0_ack) begin
            if (n_ack < 6) ack_cyc[n_ack] = cyc;
            n_ack++;
            if (n_ack == 6) c_p0_wr_req = 1'b0;
         end
         if (int'(c_tx_level) > maxl) maxl = int'(c_tx_level);
         if (ack_cyc[0] >= 0 && cyc == ack_cyc[0] + 7) lvl7 = int'(c_tx_level);
      end
      check("crd_count", n_ack, 32'd6);
      for (int i = 1; i < 6; i++)
         check($sformatf("crd_ack%0d_delta", i), ack_cyc[i] - ack_cyc[0], exp_d[i]);
      check("crd_full_level", lvl7, 32'd4);
      check("crd_max_level", maxl, 32'd4);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
